disp_bcd_mux: RTL and testbench
===============================

// Module: disp_bcd_mux
// PURPOSE
//  Display stage downstream of the reaction-timer controller. Takes its 14-bit binary value and greeting flag.
//  Converts the value to 4 BCD digits with a sequential double-dabble engine (one shift per clock).
//  Time-multiplexes the digits onto a 4-digit common-anode 7-segment display. Shows "HI" while greeting is asserted.
// PARAMETERS
//  CLK_PERIOD_NS    10    clock period in ns
//  DIGIT_PERIOD_US  1000  on-time per digit in us; refresh period R = DIGIT_PERIOD_US*1000/CLK_PERIOD_NS cycles (min 1)
// PORTS
//  i_clk       in   1   system clock, rising edge
//  i_rst       in   1   asynchronous, active-high reset
//  i_val       in   14  binary value to display (0..16383)
//  i_greeting  in   1   high: show "HI", ignore i_val for display (conversion still runs)
//  o_an        out  4   digit enables, active-low; bit 0 = rightmost digit
//  o_sseg      out  8   segments, active-low; [6:0]=g..a, [7]=dp (always 1/off)
//  o_busy      out  1   high while a conversion is in progress
//  o_ovf       out  1   high when the displayed value was clamped (source > 9999)
// BEHAVIOUR
//  Reset (async): state e_idle; r_src=0; BCD digits=0; r_ovf=0; refresh counter=0; digit select=0; o_an=4'b1111; o_sseg=8'hFF; o_busy=0.
//  FSM
//  - e_idle: if i_val != r_src, then r_src<=i_val, shift reg<=i_val, bcd<=16'h0, bit count<=0, go to e_shift. Otherwise stay.
//  - e_shift: each cycle, add 3 to every bcd nibble >=5, then shift {bcd,shift} left 1. After 14 shifts go to e_done.
//  - e_done: digit regs<=(r_src>9999) ? 4x4'd9 : bcd[15:0]; r_ovf<=(r_src>9999); go to e_idle.
//  - Default/illegal state -> e_idle.
//  Latency: i_val changes and is sampled at edge N; digit regs update at edge N+16. o_busy=1 in e_shift and e_done.
//  i_val changing during conversion: the current conversion completes unchanged. The idle compare on return starts a new one.
//    Displayed digits always come from one complete, consistent conversion (never partial).
//  Reset mid-conversion: everything returns to reset values; the next idle cycle converts i_val if nonzero.
//  Refresh: counter 0..R-1; on wrap, digit select increments mod 4 (3->0). Then o_an = ~(1<<sel).
//  o_an, o_sseg are registered (one cycle behind sel); o_an never has more than one 0 bit.
//  Segment codes (gfedcba, active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//    7=1111000 8=0000000 9=0010000 H=0001001 I=1111001 blank=1111111.
//  Greeting: digits[3:0] = blank, blank, H, I (checked before any digit logic). o_ovf still reflects the last conversion.
//  Width rules: bcd reg 16 bits (upper overflow beyond 4 digits discarded; clamp covers it). Bit counter is 4 bits.
// CONFIGURATION
//  DISP_BCD_MUX_LZ_BLANK_EN
//  - Defined: leading zero digits are blanked (segments 1111111, o_an still pulses). Digit 0 is never blanked,
//    so 0 shows "   0". Blanking stops at the first nonzero digit from the left.
//  - Undefined: all four digits always shown, e.g. 42 -> "0042".
//  - Greeting and clamp behaviour are identical in both builds.
// TESTING (override DIGIT_PERIOD_US so R=4 cycles)
//  1. i_val=1234 after reset -> o_busy high 15 cycles; digits 1,2,3,4 at edge N+16.
//     Scan sel 0..3 gives o_sseg 0011001, 0110000, 0100100, 1111001 with o_an 1110, 1101, 1011, 0111.
//  2. i_val=16383 -> displays 9999, o_ovf=1; then i_val=9999 -> o_ovf=0, 9999 displayed.
//  3. i_val=42; if DISP_BCD_MUX_LZ_BLANK_EN: digits 3,2 blank, show "  42". Else "0042". i_val=0 -> "   0" / "0000".
//  4. i_val 100->5000 at edge N+5 of a conversion -> 100 shown at N+16.
//     Second conversion starts at N+17; 5000 shown at N+33; no intermediate digit values appear.
//  5. i_greeting=1 with i_val=777 -> scan shows I, H, blank, blank (sel 0..3). Deassert -> 777 shown with no new conversion.
//  6. Assert i_rst at cycle 7 of a conversion -> o_an=1111, o_sseg=FF, o_busy=0 immediately.
//     After release with i_val=321, 321 is shown 16 cycles later.

Source files
------------

// File: rtl/disp_bcd_mux.sv
// rtl/disp_bcd_mux.sv - sequential binary-to-BCD conversion driving a 4-digit multiplexed 7-segment display
// Build option: define DISP_BCD_MUX_LZ_BLANK_EN to blank leading zero digits.
module disp_bcd_mux #(
  parameter int CLK_PERIOD_NS   = 10,
  parameter int DIGIT_PERIOD_US = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [13:0] i_val,
  input  logic        i_greeting,
  output logic [3:0]  o_an,
  output logic [7:0]  o_sseg,
  output logic        o_busy,
  output logic        o_ovf
);

  localparam int            R_RAW  = DIGIT_PERIOD_US * 1000 / CLK_PERIOD_NS;
  localparam int            R      = (R_RAW < 1) ? 1 : R_RAW;
  localparam int            RW     = (R > 1) ? $clog2(R) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(R - 1);

  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_I     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {e_idle, e_shift, e_done} state_t;

  state_t        r_state;
  logic [13:0]   r_src;
  logic [13:0]   r_sh;
  logic [15:0]   r_bcd;
  logic [15:0]   r_dig;
  logic [3:0]    r_cnt;
  logic          r_ovf;
  logic          r_busy;
  logic [RW-1:0] r_rcnt;
  logic [1:0]    r_sel;
  logic [3:0]    r_an;
  logic [7:0]    r_sseg;

  logic [15:0]   w_adj;
  logic [3:0]    w_nib;
  logic          w_blank;
  logic [6:0]    w_seg;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  // One extra e_shift cycle after the 14th shift keeps capture-to-digits at 16 edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= e_idle;
      r_src   <= '0;
      r_sh    <= '0;
      r_bcd   <= '0;
      r_dig   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        e_idle: begin
          r_busy <= 1'b0;
          if (i_val != r_src) begin
            r_src   <= i_val;
            r_sh    <= i_val;
            r_bcd   <= 16'h0;
            r_cnt   <= 4'd0;
            r_state <= e_shift;
          end
        end
        e_shift: begin
          r_busy <= 1'b1;
          if (r_cnt == 4'd14) begin
            r_state <= e_done;
          end else begin
            {r_bcd, r_sh} <= {w_adj[14:0], r_sh, 1'b0};
            r_cnt         <= r_cnt + 4'd1;
          end
        end
        e_done: begin
          r_busy  <= 1'b0;
          r_dig   <= (r_src > 14'd9999) ? 16'h9999 : r_bcd;
          r_ovf   <= (r_src > 14'd9999);
          r_state <= e_idle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= e_idle;
        end
      endcase
    end
  end

  always_comb begin
    w_nib = r_dig[{r_sel, 2'b00} +: 4];
`ifdef DISP_BCD_MUX_LZ_BLANK_EN
    case (r_sel)
      2'd3:    w_blank = (r_dig[15:12] == 4'd0);
      2'd2:    w_blank = (r_dig[15:8] == 8'd0);
      2'd1:    w_blank = (r_dig[15:4] == 12'd0);
      default: w_blank = 1'b0;
    endcase
`else
    w_blank = 1'b0;
`endif
    w_seg = SEG_BLANK;
    if (i_greeting) begin
      if (r_sel == 2'd0)      w_seg = SEG_I;
      else if (r_sel == 2'd1) w_seg = SEG_H;
      else                    w_seg = SEG_BLANK;
    end else if (!w_blank) begin
      case (w_nib)
        4'd0:    w_seg = 7'b1000000;
        4'd1:    w_seg = 7'b1111001;
        4'd2:    w_seg = 7'b0100100;
        4'd3:    w_seg = 7'b0110000;
        4'd4:    w_seg = 7'b0011001;
        4'd5:    w_seg = 7'b0010010;
        4'd6:    w_seg = 7'b0000010;
        4'd7:    w_seg = 7'b1111000;
        4'd8:    w_seg = 7'b0000000;
        4'd9:    w_seg = 7'b0010000;
        default: w_seg = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rcnt <= '0;
      r_sel  <= 2'd0;
      r_an   <= 4'b1111;
      r_sseg <= 8'hFF;
    end else begin
      if (r_rcnt == R_LAST) begin
        r_rcnt <= '0;
        r_sel  <= r_sel + 2'd1;
      end else begin
        r_rcnt <= r_rcnt + RW'(1);
      end
      r_an   <= ~(4'b0001 << r_sel);
      r_sseg <= {1'b1, w_seg};
    end
  end

  assign o_an   = r_an;
  assign o_sseg = r_sseg;
  assign o_busy = r_busy;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_disp_bcd_mux.sv
// tb/tb_disp_bcd_mux.sv - directed self-checking bench for disp_bcd_mux (refresh period 4 cycles)
`timescale 1ns/1ps
module tb_disp_bcd_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] val = 14'd0;
  logic        greet = 1'b0;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        busy;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int busy_seen = 0;

  disp_bcd_mux #(.CLK_PERIOD_NS(250), .DIGIT_PERIOD_US(1)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_val      (val),
    .i_greeting (greet),
    .o_an       (an),
    .o_sseg     (sseg),
    .o_busy     (busy),
    .o_ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_code(input int v, input bit g, input int idx);
    int vv;
    int p;
    if (g) return (idx == 0) ? 8'hF9 : (idx == 1) ? 8'h89 : 8'hFF;
    vv = (v > 9999) ? 9999 : v;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
`ifdef DISP_BCD_MUX_LZ_BLANK_EN
    if (idx > 0 && vv < p) return 8'hFF;
`endif
    return seg_of((vv / p) % 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string tag, input int v, input bit g);
    int idx;
    logic [3:0] pat;
    idx = -1;
    for (int k = 0; k < 4; k++) begin
      pat = 4'b0001 << k;
      if (an == ~pat) idx = k;
    end
    chk({tag, "_an_onecold"}, 32'(idx >= 0), 32'd1);
    if (idx >= 0) chk({tag, "_seg"}, 32'(sseg), 32'(exp_code(v, g, idx)));
    if (busy) busy_seen++;
  endtask

  task automatic run_check(input string tag, input int v, input bit g, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_now(tag, v, g);
    end
  endtask

  task automatic scan(input string tag, input int v, input bit g);
    logic [3:0] pat;
    bit found;
    for (int k = 0; k < 4; k++) begin
      pat = ~(4'b0001 << k);
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
        tick();
        if (an == pat) found = 1'b1;
      end
      chk($sformatf("%s_sel%0d_found", tag, k), 32'(found), 32'd1);
      if (found) chk($sformatf("%s_sel%0d_seg", tag, k), 32'(sseg), 32'(exp_code(v, g, k)));
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_sseg", 32'(sseg), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    busy_seen = 0;
    run_check("idle0", 0, 1'b0, 6);
    chk("idle0_busy", busy_seen, 0);

    // 1234: busy for 15 cycles, new digits visible on o_sseg 17 edges after capture
    val = 14'd1234;
    tick();
    busy_seen = 0;
    run_check("t1_old", 0, 1'b0, 16);
    chk("t1_busy_cycles", busy_seen, 15);
    run_check("t1_new", 1234, 1'b0, 4);
    scan("t1_scan", 1234, 1'b0);
    chk("t1_ovf", 32'(ovf), 32'd0);

    val = 14'd16383;
    tick();
    run_check("t2_old", 1234, 1'b0, 16);
    run_check("t2_new", 16383, 1'b0, 4);
    chk("t2_ovf", 32'(ovf), 32'd1);
    scan("t2_scan", 16383, 1'b0);

    val = 14'd9999;
    tick();
    run_check("t2b_old", 9999, 1'b0, 15);
    chk("t2b_ovf_hold", 32'(ovf), 32'd1);
    run_check("t2b_new", 9999, 1'b0, 1);
    chk("t2b_ovf_clear", 32'(ovf), 32'd0);
    run_check("t2b_after", 9999, 1'b0, 4);

    val = 14'd42;
    tick();
    run_check("t3_old", 9999, 1'b0, 16);
    run_check("t3_new", 42, 1'b0, 4);
    scan("t3_scan42", 42, 1'b0);

    val = 14'd0;
    tick();
    run_check("t3z_old", 42, 1'b0, 16);
    run_check("t3z_new", 0, 1'b0, 4);
    scan("t3_scan0", 0, 1'b0);

    // input changes mid-conversion: 100 completes, then 5000 follows
    val = 14'd100;
    tick();
    run_check("t4_pre", 0, 1'b0, 5);
    val = 14'd5000;
    run_check("t4_old", 0, 1'b0, 11);
    run_check("t4_100", 100, 1'b0, 17);
    run_check("t4_5000", 5000, 1'b0, 4);

    val = 14'd777;
    tick();
    run_check("t5_old", 5000, 1'b0, 16);
    run_check("t5_new", 777, 1'b0, 4);
    greet = 1'b1;
    run_check("t5_greet", 777, 1'b1, 4);
    scan("t5_gscan", 777, 1'b1);
    chk("t5_ovf", 32'(ovf), 32'd0);
    greet = 1'b0;
    busy_seen = 0;
    run_check("t5_back", 777, 1'b0, 20);
    chk("t5_no_conv", busy_seen, 0);

    // reset mid-conversion
    val = 14'd321;
    tick();
    run_check("t6_pre", 777, 1'b0, 7);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_an", 32'(an), 32'hF);
    chk("t6_rst_sseg", 32'(sseg), 32'hFF);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    chk("t6_hold_an", 32'(an), 32'hF);
    rst = 1'b0;
    tick();
    run_check("t6_old", 0, 1'b0, 16);
    run_check("t6_new", 321, 1'b0, 4);
    scan("t6_scan", 321, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
